// File: rtl/npc_pkg.sv
// Shared next-PC definitions: op encoding, op width and default reset PC.
// The decode stage drives D_npc_op using the NPC_* constants from this package.
package npc_pkg;

    localparam int NPC_OP_W = 3;

    typedef logic [NPC_OP_W-1:0] npc_op_t;

    localparam npc_op_t NPC_PC4 = 3'd0;
    localparam npc_op_t NPC_BEQ = 3'd1;
    localparam npc_op_t NPC_BNE = 3'd2;
    localparam npc_op_t NPC_J   = 3'd3;
    localparam npc_op_t NPC_JR  = 3'd4;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          PC_STEP_DEFAULT  = 4;

    // Conditional branches are the only ops that consult the compare result.
    function automatic logic is_cond_branch(input npc_op_t op);
        return (op == NPC_BEQ) || (op == NPC_BNE);
    endfunction

endpackage

// File: rtl/f_pc_npc_if.sv
// D-stage to fetch next-PC bundle: branch/jump fields in, fetch PC and link out.
// master = decode/hazard side, slave = f_pc_npc.
interface f_pc_npc_if;
    import npc_pkg::*;

    logic        stall;
    npc_op_t     D_npc_op;
    logic [31:0] D_pc;
    logic [15:0] D_imm16;
    logic [25:0] D_index26;
    logic [31:0] D_rs_data;
    logic        D_cmp_eq;
    logic [31:0] F_pc;
    logic [31:0] D_link;
    logic        D_redirect;

    modport master (
        output stall, D_npc_op, D_pc, D_imm16, D_index26, D_rs_data, D_cmp_eq,
        input  F_pc, D_link, D_redirect
    );

    modport slave (
        input  stall, D_npc_op, D_pc, D_imm16, D_index26, D_rs_data, D_cmp_eq,
        output F_pc, D_link, D_redirect
    );

endinterface

// File: rtl/npc_calc.sv
// Combinational redirect decision, target and link address for the D-stage instruction.
// All adds wrap modulo 2^32; jr targets are taken verbatim.
module npc_calc
    import npc_pkg::*;
(
    input  npc_op_t     npc_op,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] rs_data,
    input  logic        cmp_eq,
    output logic [31:0] target,
    output logic        redirect,
    output logic [31:0] link
);

    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Sign-extend before shifting so backward branches stay negative.
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target = pc + 32'd4 + br_offset;
    assign j_target  = {pc[31:28], index26, 2'b00};
    assign link      = pc + 32'd8;

    always_comb begin
        target   = br_target;
        redirect = 1'b0;
        unique case (npc_op)
            NPC_BEQ: begin
                target   = br_target;
                redirect = cmp_eq;
            end
            NPC_BNE: begin
                target   = br_target;
                redirect = !cmp_eq;
            end
            NPC_J: begin
                target   = j_target;
                redirect = 1'b1;
            end
            NPC_JR: begin
                target   = rs_data;
                redirect = 1'b1;
            end
            default: begin
                target   = br_target;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/f_pc_npc.sv
// Fetch PC register with next-PC selection (delay-slot semantics, no flush).
// Optional branch statistics counters are built when NPC_BRANCH_STATS_EN is defined.
module f_pc_npc
    import npc_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    f_pc_npc_if.slave   bus
`ifdef NPC_BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_taken
`endif
);

    logic [31:0] pc_q;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] link;

    npc_calc u_calc (
        .npc_op   (bus.D_npc_op),
        .pc       (bus.D_pc),
        .imm16    (bus.D_imm16),
        .index26  (bus.D_index26),
        .rs_data  (bus.D_rs_data),
        .cmp_eq   (bus.D_cmp_eq),
        .target   (target),
        .redirect (redirect),
        .link     (link)
    );

    // Redirect lands one fetch late: the delay-slot instruction is already in F.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else if (bus.stall) begin
            pc_q <= pc_q;
        end else if (redirect) begin
            pc_q <= target;
        end else begin
            pc_q <= pc_q + 32'(PC_STEP);
        end
    end

    assign bus.F_pc       = pc_q;
    assign bus.D_link     = link;
    // Not stall-gated; consumers qualify with !stall.
    assign bus.D_redirect = redirect;

`ifdef NPC_BRANCH_STATS_EN
    logic cond_resolved;

    assign cond_resolved = !bus.stall && is_cond_branch(bus.D_npc_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches <= '0;
            stat_taken    <= '0;
        end else if (cond_resolved) begin
            if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
            if (redirect && (stat_taken != '1)) stat_taken <= stat_taken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_f_pc_npc.sv
// Self-checking bench for f_pc_npc: expected F_pc values are queued when a cycle is
// driven and popped after the clock edge; stats checks run when NPC_BRANCH_STATS_EN is set.
module tb_f_pc_npc;
    import npc_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];

    f_pc_npc_if bus ();

`ifdef NPC_BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
`endif

    f_pc_npc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef NPC_BRANCH_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic m_redir(input npc_op_t op, input logic eq);
        case (op)
            NPC_BEQ: return eq;
            NPC_BNE: return !eq;
            NPC_J,
            NPC_JR:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_tgt(input npc_op_t op, input logic [31:0] pc,
                                          input logic [15:0] imm, input logic [25:0] idx,
                                          input logic [31:0] rs);
        logic [31:0] sx;
        sx = {{16{imm[15]}}, imm};
        case (op)
            NPC_J:   return {pc[31:28], idx, 2'b00};
            NPC_JR:  return rs;
            default: return pc + 32'd4 + (sx << 2);
        endcase
    endfunction

    // One clock: drive at negedge, check combinational outputs, queue expected F_pc.
    task automatic cycle(input logic rst, input logic stl, input npc_op_t op,
                         input logic [31:0] pc, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs, input logic eq);
        logic        rd;
        logic [31:0] nxt;
        logic [31:0] exp;
        @(negedge clk);
        reset         = rst;
        bus.stall     = stl;
        bus.D_npc_op  = op;
        bus.D_pc      = pc;
        bus.D_imm16   = imm;
        bus.D_index26 = idx;
        bus.D_rs_data = rs;
        bus.D_cmp_eq  = eq;
        #1;
        rd = m_redir(op, eq);
        chk("redirect", {31'd0, bus.D_redirect}, {31'd0, rd});
        chk("link", bus.D_link, pc + 32'd8);
        if (rst)      nxt = 32'h0000_3000;
        else if (stl) nxt = model_pc;
        else if (rd)  nxt = m_tgt(op, pc, imm, idx, rs);
        else          nxt = model_pc + 32'd4;
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        chk("f_pc", bus.F_pc, exp);
        model_pc = exp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, NPC_PC4, model_pc, 16'h0, 26'h0, 32'h0, 1'b0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        model_pc = 32'h0;
        reset    = 1'b1;
        bus.stall = 1'b0;
        bus.D_npc_op = NPC_PC4;
        bus.D_pc = '0;
        bus.D_imm16 = '0;
        bus.D_index26 = '0;
        bus.D_rs_data = '0;
        bus.D_cmp_eq = 1'b0;

        // 1: reset then free-running fall-through
        cycle(1'b1, 1'b0, NPC_PC4, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("t1_reset", bus.F_pc, 32'h0000_3000);
        idle(3);
        chk("t1_seq", bus.F_pc, 32'h0000_300C);

        // 2: backward beq taken, then not taken
        cycle(1'b0, 1'b0, NPC_BEQ, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 1'b1);
        chk("t2_beq_taken", bus.F_pc, 32'h0000_3004);
        cycle(1'b0, 1'b0, NPC_BEQ, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 1'b0);
        chk("t2_beq_fall", bus.F_pc, 32'h0000_3008);

        // 3: bne taken, then j with link
        cycle(1'b0, 1'b0, NPC_BNE, 32'h3000, 16'h0003, 26'h0, 32'h0, 1'b0);
        chk("t3_bne", bus.F_pc, 32'h0000_3010);
        cycle(1'b0, 1'b0, NPC_J, 32'h3010, 16'h0, 26'h0000C40, 32'h0, 1'b0);
        chk("t3_j", bus.F_pc, 32'h0000_3100);
        chk("t3_link", bus.D_link, 32'h0000_3018);

        // 4: jr held by stall for two cycles
        cycle(1'b0, 1'b1, NPC_JR, 32'h3100, 16'h0, 26'h0, 32'h3ABC, 1'b0);
        cycle(1'b0, 1'b1, NPC_JR, 32'h3100, 16'h0, 26'h0, 32'h3ABC, 1'b0);
        chk("t4_hold", bus.F_pc, 32'h0000_3100);
        cycle(1'b0, 1'b0, NPC_JR, 32'h3100, 16'h0, 26'h0, 32'h3ABC, 1'b0);
        chk("t4_jr", bus.F_pc, 32'h0000_3ABC);

        // 5: reset beats pending jr; link and PC wrap; reserved ops and reset over stall
        cycle(1'b0, 1'b0, NPC_J, 32'h3000, 16'h0, 26'h0000C08, 32'h0, 1'b0);
        chk("t5_pre", bus.F_pc, 32'h0000_3020);
        cycle(1'b1, 1'b0, NPC_JR, 32'h301C, 16'h0, 26'h0, 32'h5555_0000, 1'b0);
        chk("t5_reset_jr", bus.F_pc, 32'h0000_3000);
        cycle(1'b0, 1'b0, NPC_PC4, 32'hFFFF_FFF8, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("t5_link_wrap", bus.D_link, 32'h0000_0000);
        cycle(1'b0, 1'b0, NPC_JR, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
        idle(1);
        chk("t5_pc_wrap", bus.F_pc, 32'h0000_0000);
        for (int op = 5; op < 8; op++) cycle(1'b0, 1'b0, npc_op_t'(op), 32'h40, 16'h7FFF, 26'h3FFFFFF, 32'h1234, 1'b1);
        chk("t5_reserved", bus.F_pc, 32'h0000_000C);
        cycle(1'b1, 1'b1, NPC_J, 32'h8000_0000, 16'h0, 26'h1, 32'h0, 1'b0);
        chk("t5_reset_stall", bus.F_pc, 32'h0000_3000);

        // random mixed stream through the scoreboard
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                  npc_op_t'($urandom_range(0, 7)), {$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC,
                  16'($urandom), 26'($urandom), $urandom, 1'($urandom));
        end

`ifdef NPC_BRANCH_STATS_EN
        // 6: branch statistics
        cycle(1'b1, 1'b0, NPC_PC4, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("t6_rst_br", stat_branches, 32'd0);
        chk("t6_rst_tk", stat_taken, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, NPC_BEQ, 32'h3000, 16'h0004, 26'h0, 32'h0, (i < 3));
        cycle(1'b0, 1'b1, NPC_BEQ, 32'h3000, 16'h0004, 26'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, NPC_J, 32'h3000, 16'h0, 26'h0000C00, 32'h0, 1'b0);
        chk("t6_branches", stat_branches, 32'd5);
        chk("t6_taken", stat_taken, 32'd3);
`endif

        if (exp_q.size() != 0) chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
